// File: rtl/video_stream_gen_if.sv
// rtl/video_stream_gen_if.sv - pixel/strobe stream bundle between generator and scaler
interface video_stream_gen_if #(
  parameter int PIXEL_WIDTH = 12
);
  logic [PIXEL_WIDTH-1:0] do_o;
  logic                   de_o;
  logic                   hs_o;
  logic                   vs_o;

  modport master (output do_o, de_o, hs_o, vs_o);
  modport slave  (input  do_o, de_o, hs_o, vs_o);
endinterface

// File: rtl/video_stream_gen.sv
// rtl/video_stream_gen.sv - synthetic test-pattern video source with blanking and sparse pacing
module video_stream_gen #(
  parameter int PIXEL_WIDTH = 12,
  parameter int SPARSE_OUT  = 0,
  parameter int LINE_GAP    = 16,
  parameter int FRAME_GAP   = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [15:0]               line_size,
  input  logic [15:0]               line_count,
  input  logic [1:0]                pattern_sel,
  video_stream_gen_if.master        vid,
  output logic                      busy_o,
  output logic                      frame_done_o
);

  typedef enum logic [2:0] {IDLE, START, LINE, LGAP, FGAP} state_t;

  // Terminal counts for the shared slot/gap counter
  localparam logic [15:0] SP_LAST = 16'(SPARSE_OUT);
  localparam logic [15:0] LG_LAST = 16'(LINE_GAP - 1);
  localparam logic [15:0] FG_LAST = 16'(FRAME_GAP);
  localparam logic [15:0] FG_PRE  = 16'(FRAME_GAP - 1);

  state_t state, state_d;
  logic [15:0] x, x_d, y, y_d, cnt, cnt_d;
  logic [15:0] size_q, size_d, count_q, count_d;
  logic [1:0]  pat_q, pat_d;
  logic [15:0] sum;
  logic [PIXEL_WIDTH-1:0] pix, do_d;
  logic de_d, hs_d, vs_d, busy_d, fd_d;
  logic go;

  assign go = enable && (line_size != 16'd0) && (line_count != 16'd0);

  // Pixel value for the current (x, y) under the latched pattern
  always_comb begin
    sum = x + y;
    case (pat_q)
      2'd0:    pix = PIXEL_WIDTH'(x);
      2'd1:    pix = PIXEL_WIDTH'(y);
      2'd2:    pix = (x[3] ^ y[3]) ? '1 : '0;
      default: pix = PIXEL_WIDTH'(sum);
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state, counter and output-next logic; pixel outputs trail the state by one cycle
  always_comb begin
    state_d = state;
    x_d     = x;
    y_d     = y;
    cnt_d   = cnt;
    size_d  = size_q;
    count_d = count_q;
    pat_d   = pat_q;
    case (state)
      IDLE: begin
        if (go) state_d = START;
      end
      START: begin
        size_d  = line_size;
        count_d = line_count;
        pat_d   = pattern_sel;
        x_d     = 16'd0;
        y_d     = 16'd0;
        cnt_d   = 16'd0;
        state_d = LINE;
      end
      LINE: begin
        if (cnt == SP_LAST) begin
          cnt_d = 16'd0;
          if (x == size_q - 16'd1) state_d = (y == count_q - 16'd1) ? FGAP : LGAP;
          else                     x_d = x + 16'd1;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      LGAP: begin
        if (cnt == LG_LAST) begin
          cnt_d   = 16'd0;
          x_d     = 16'd0;
          y_d     = y + 16'd1;
          state_d = LINE;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      FGAP: begin
        if (cnt == FG_LAST) begin
          cnt_d   = 16'd0;
          state_d = go ? START : IDLE;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    de_d   = (state == LINE) && (cnt == 16'd0);
    do_d   = de_d ? pix : '0;
    hs_d   = de_d && (x == 16'd0);
    vs_d   = hs_d && (y == 16'd0);
    busy_d = (state_d != IDLE);
    fd_d   = (state == FGAP) && (cnt == FG_PRE);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x            <= 16'd0;
      y            <= 16'd0;
      cnt          <= 16'd0;
      size_q       <= 16'd0;
      count_q      <= 16'd0;
      pat_q        <= 2'd0;
      vid.do_o     <= '0;
      vid.de_o     <= 1'b0;
      vid.hs_o     <= 1'b0;
      vid.vs_o     <= 1'b0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      x            <= x_d;
      y            <= y_d;
      cnt          <= cnt_d;
      size_q       <= size_d;
      count_q      <= count_d;
      pat_q        <= pat_d;
      vid.do_o     <= do_d;
      vid.de_o     <= de_d;
      vid.hs_o     <= hs_d;
      vid.vs_o     <= vs_d;
      busy_o       <= busy_d;
      frame_done_o <= fd_d;
    end
  end

endmodule
